if_prefetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the in-order pipeline core. It replaces the fixed single-cycle fetch stage: it decouples fetch from decode through a DEPTH-entry instruction queue and talks to instruction memory through a request/grant/response handshake with variable latency. It supports up to MAX_OUTSTANDING in-flight requests and discards stale responses after a taken jump. It feeds PC_IF/IR_IF to the decode stage and consumes the same stall/jump_taken/jump_addr flow-control signals as the rest of the pipeline.

---
 rtl/if_prefetch_queue_pkg.sv | 18 +
 rtl/if_prefetch_queue_sync_fifo.sv | 63 ++++++
 rtl/if_prefetch_queue.sv | 114 +++++++++++
 tb/tb_if_prefetch_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_queue_pkg.sv
// Shared core constants and types for the instruction-fetch front end.
// Holds the word size, the NOP encoding and the sequential PC step.
package if_prefetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/if_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with a flush that empties it in one cycle.
// Pointers wrap naturally (DEPTH is a power of two); count tells full from empty.
module if_prefetch_queue_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && !flush && (count_q != '0);
        // A push into a full queue is only accepted alongside a pop.
        do_push  = push && !flush && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues imem requests under a credit limit,
// queues in-order responses for decode and drops stale ones after a redirect.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_VEC       = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            jump_taken,
    input  logic [XLEN-1:0] jump_addr,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_ena,
    input  logic            imem_gnt,
    input  logic [XLEN-1:0] imem_din,
    input  logic            imem_rvalid,
    output logic [XLEN-1:0] PC_IF,
    output logic [XLEN-1:0] IR_IF,
    output logic            valid_IF
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int OUT_W   = 3;
    localparam int CRED_W  = CNT_W + OUT_W + 1;
    localparam int ENTRY_W = $bits(fetch_entry_t);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] discard_q, discard_d;

    logic [CNT_W-1:0]  fifo_count;
    logic [CRED_W-1:0] credit;
    logic              rsp_ok, issue, fifo_push, fifo_pop;
    fetch_entry_t      push_entry, head_entry;
    logic [ENTRY_W-1:0] head_raw;

    always_comb begin
        // A response with nothing outstanding is a protocol violation and is ignored.
        rsp_ok = imem_rvalid && (outstanding_q != '0);
        // Slots already promised: queued words plus kept in-flight words.
        credit = CRED_W'(fifo_count) + CRED_W'(outstanding_q) - CRED_W'(discard_q);
        imem_ena = !reset && !jump_taken
                   && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                   && (credit < CRED_W'(DEPTH));
        issue = imem_ena && imem_gnt;

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        fifo_push     = 1'b0;
        outstanding_d = outstanding_q + OUT_W'(issue) - OUT_W'(rsp_ok);

        if (jump_taken) begin
            fetch_pc_d = align_word(jump_addr);
            resp_pc_d  = align_word(jump_addr);
            discard_d  = outstanding_q - OUT_W'(rsp_ok);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + PC_INC;
            if (rsp_ok) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - 1'b1;
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + PC_INC;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_VEC;
            resp_pc_q     <= RESET_VEC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign push_entry = '{pc: resp_pc_q, ir: imem_din};
    assign fifo_pop   = valid_IF && !stall;

    if_prefetch_queue_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_sync_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (jump_taken),
        .din   (push_entry),
        .dout  (head_raw),
        .count (fifo_count)
    );

    assign head_entry = head_raw;
    assign valid_IF   = (fifo_count != '0);
    assign PC_IF      = valid_IF ? head_entry.pc : resp_pc_q;
    assign IR_IF      = valid_IF ? head_entry.ir : NOP;
    assign imem_addr  = fetch_pc_q;

    rvalid_needs_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (outstanding_q == '0)));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: a memory model serves requests and
// a monitor checks every consumed head entry against the expected PC stream.
module tb_if_prefetch_queue;

    localparam int          MAX_OUT   = 2;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, jump_taken;
    logic [31:0] jump_addr, imem_addr, imem_din, PC_IF, IR_IF;
    logic        imem_ena, imem_gnt, imem_rvalid, valid_IF;

    int n_cmp = 0, n_bad = 0, n_pop = 0, cyc = 0, tb_out = 0;
    int lat_min = 1, lat_max = 1;
    bit gnt_rand = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_pc;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend_q[$];

    if_prefetch_queue #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_VEC       (RESET_VEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .jump_taken  (jump_taken),
        .jump_addr   (jump_addr),
        .imem_addr   (imem_addr),
        .imem_ena    (imem_ena),
        .imem_gnt    (imem_gnt),
        .imem_din    (imem_din),
        .imem_rvalid (imem_rvalid),
        .PC_IF       (PC_IF),
        .IR_IF       (IR_IF),
        .valid_IF    (valid_IF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Called at posedge+1: redirect and reload the scoreboard for the target stream.
    task automatic do_jump(input logic [31:0] addr);
        logic [31:0] tgt;
        tgt = addr & ~32'd3;
        jump_taken = 1'b1;
        jump_addr  = addr;
        exp_q.delete();
        push_seq(tgt, 512);
        exp_addr = tgt;
        $display("jump to %h (target %h)", addr, tgt);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: drives grant and in-order responses after the programmed latency.
    initial begin
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_din = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pend_q.delete();
                imem_rvalid = 1'b0;
            end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_din = mem_word(pend_q[0].addr);
                pend_q.delete(0);
            end else begin
                imem_rvalid = 1'b0;
                imem_din = 32'h0;
            end
            imem_gnt = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Request monitor: every accepted request must follow the expected address stream.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            tb_out = 0;
        end else begin
            if (imem_rvalid) tb_out--;
            if (imem_ena && imem_gnt) begin
                check("req_addr", imem_addr, exp_addr);
                pend_q.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_min, lat_max)});
                exp_addr = exp_addr + 32'd4;
                tb_out++;
                check("outstanding_cap", 32'(tb_out > MAX_OUT), 32'd0);
            end
        end
    end

    // Output monitor: pops the scoreboard whenever decode consumes the head entry.
    initial forever begin
        @(negedge clk);
        if (reset === 1'b0 && valid_IF && !stall && !jump_taken) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got pc %h expected no entry", PC_IF);
            end else begin
                mon_pc = exp_q.pop_front();
                check("pop_pc", PC_IF, mon_pc);
                check("pop_ir", IR_IF, mem_word(mon_pc));
                $display("pop pc=%h ir=%h", PC_IF, IR_IF);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, found;
        reset = 1'b1; stall = 1'b0; jump_taken = 1'b0; jump_addr = 32'h0;
        exp_addr = RESET_VEC;
        push_seq(RESET_VEC, 512);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ena", imem_ena, 1'b0);
        check("rst_addr", imem_addr, RESET_VEC);
        check("rst_pc", PC_IF, RESET_VEC);
        check("rst_ir", IR_IF, NOP);
        check("rst_valid", valid_IF, 1'b0);

        // Zero-wait streaming from reset.
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("c0_ena", imem_ena, 1'b1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", valid_IF, 1'b0);
        next_cycle();
        @(negedge clk);
        check("c1_addr", imem_addr, 32'h4);
        check("c1_valid", valid_IF, 1'b0);
        next_cycle();
        @(negedge clk);
        check("c2_valid", valid_IF, 1'b1);
        check("c2_pc", PC_IF, 32'h0);
        next_cycle();
        p = n_pop;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stream_ena", imem_ena, 1'b1);
            next_cycle();
        end
        check("sustained_rate", 32'(n_pop - p), 32'd10);

        // Stall for 10 cycles: queue fills and requests stop.
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                check("stall_ena_off", imem_ena, 1'b0);
                check("stall_valid", valid_IF, 1'b1);
            end
            next_cycle();
        end
        check("stall_inflight", 32'(tb_out), 32'd0);
        p = n_pop;
        stall = 1'b0;
        repeat (4) next_cycle();
        check("full_drain", 32'(n_pop - p), 32'd4);

        // Flush with two requests in flight.
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            next_cycle();
            if (tb_out == 2) found = 1;
        end
        check("two_in_flight", 32'(tb_out), 32'd2);
        do_jump(32'h0000_0103);
        @(negedge clk);
        check("flush_no_issue", imem_ena, 1'b0);
        next_cycle();
        jump_taken = 1'b0;
        p = n_pop;
        for (int i = 0; i < 20 && n_pop == p; i++) next_cycle();
        check("flush_first_pop", 32'(n_pop > p), 32'd1);

        // Redirect coinciding with a response and a pop, zero-wait memory.
        lat_min = 1; lat_max = 1;
        repeat (8) next_cycle();
        do_jump(32'h0000_0200);
        @(negedge clk);
        check("jt_valid", valid_IF, 1'b1);
        next_cycle();
        jump_taken = 1'b0;
        @(negedge clk);
        check("t1_valid", valid_IF, 1'b0);
        check("t1_ir", IR_IF, NOP);
        check("t1_ena", imem_ena, 1'b1);
        check("t1_addr", imem_addr, 32'h0000_0200);
        next_cycle();
        @(negedge clk);
        check("t2_valid", valid_IF, 1'b0);
        next_cycle();
        @(negedge clk);
        check("t3_valid", valid_IF, 1'b1);
        check("t3_pc", PC_IF, 32'h0000_0200);
        next_cycle();

        // Variable grant and latency with random stalls and a mid-run redirect.
        lat_min = 1; lat_max = 5; gnt_rand = 1'b1;
        p = n_pop;
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            if (i == 150) do_jump(32'h0000_0400);
            else jump_taken = 1'b0;
            next_cycle();
        end
        stall = 1'b0; jump_taken = 1'b0;
        check("random_progress", 32'(n_pop - p >= 40), 32'd1);

        // Address wrap.
        gnt_rand = 1'b0; lat_min = 1; lat_max = 1;
        repeat (12) next_cycle();
        do_jump(32'hFFFF_FFFC);
        next_cycle();
        jump_taken = 1'b0;
        @(negedge clk);
        check("wrap_ena0", imem_ena, 1'b1);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        next_cycle();
        @(negedge clk);
        check("wrap_ena1", imem_ena, 1'b1);
        check("wrap_addr1", imem_addr, 32'h0000_0000);
        next_cycle();
        p = n_pop;
        repeat (10) next_cycle();
        check("wrap_progress", 32'(n_pop - p >= 5), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
